// File: rtl/soc_timer_cmd_seq.sv
`default_nettype none
// ============================================================================
//  Module   : soc_timer_cmd_seq
//  Brief    : Expands START/STOP/CLEAR/READ64 commands into ordered register
//             transactions on the SoC timer req/gnt/r_valid port.
//  Revision : 1.0 - initial release
// ============================================================================
module soc_timer_cmd_seq #(
    parameter int ID_WIDTH  = 5,
    parameter int TXN_ID    = 0,
    parameter int MAX_RETRY = 3
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [1:0]          cmd_op_i,
    input  logic [31:0]         cmd_period_i,
    input  logic                cmd_oneshot_i,
    input  logic [7:0]          cmd_presc_i,
    output logic                rsp_valid_o,
    output logic [63:0]         rsp_data_o,
    output logic                rsp_err_o,
    output logic                tmr_req_o,
    output logic [31:0]         tmr_addr_o,
    output logic                tmr_wen_o,
    output logic [31:0]         tmr_wdata_o,
    output logic [3:0]          tmr_be_o,
    output logic [ID_WIDTH-1:0] tmr_id_o,
    input  logic                tmr_gnt_i,
    input  logic                tmr_r_valid_i,
    input  logic [31:0]         tmr_r_rdata_i
);

    localparam int c_RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [c_RETRY_W-1:0] c_MAX_RETRY = c_RETRY_W'(MAX_RETRY);
    localparam logic [ID_WIDTH-1:0]  c_TXN_ID    = ID_WIDTH'(TXN_ID);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_ISSUE = 2'd1;
    localparam logic [1:0] c_S_WAIT  = 2'd2;
    localparam logic [1:0] c_S_RESP  = 2'd3;

    localparam logic [1:0] c_OP_START  = 2'd0;
    localparam logic [1:0] c_OP_STOP   = 2'd1;
    localparam logic [1:0] c_OP_CLEAR  = 2'd2;
    localparam logic [1:0] c_OP_READ64 = 2'd3;

    localparam logic [31:0] c_A_CFG_LO = 32'h0000_0000;
    localparam logic [31:0] c_A_VAL_LO = 32'h0000_0008;
    localparam logic [31:0] c_A_VAL_HI = 32'h0000_000C;
    localparam logic [31:0] c_A_CMP_LO = 32'h0000_0010;

    logic [1:0]           r_state;
    logic [1:0]           r_op;
    logic [31:0]          r_period;
    logic                 r_oneshot;
    logic [7:0]           r_presc;
    logic [1:0]           r_step;
    logic [c_RETRY_W-1:0] r_retry;
    logic [31:0]          r_h0;
    logic [31:0]          r_lo;
    logic [31:0]          r_shadow;
    logic [63:0]          r_rsp_data;
    logic                 r_rsp_err;

    logic [31:0] w_cfg_start;
    logic [31:0] w_addr;
    logic        w_wen;
    logic [31:0] w_wdata;
    logic        w_last;
    logic        w_issue;

    // enable|reset|irq|cmp_clr plus one-shot and prescaler fields; mode64 stays 0
    assign w_cfg_start = {16'h0000, r_presc, 1'b0, (r_presc != 8'd0), r_oneshot,
                          1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    always_comb begin
        w_addr  = c_A_CFG_LO;
        w_wen   = 1'b1;
        w_wdata = 32'h0000_0000;
        w_last  = 1'b0;
        case (r_op)
            c_OP_START: begin
                w_wen  = 1'b0;
                w_last = (r_step == 2'd2);
                case (r_step)
                    2'd0: begin
                        w_addr  = c_A_CFG_LO;
                        w_wdata = 32'h0000_0000;
                    end
                    2'd1: begin
                        w_addr  = c_A_CMP_LO;
                        w_wdata = r_period;
                    end
                    default: begin
                        w_addr  = c_A_CFG_LO;
                        w_wdata = w_cfg_start;
                    end
                endcase
            end
            c_OP_STOP: begin
                w_wen   = 1'b0;
                w_last  = 1'b1;
                w_addr  = c_A_CFG_LO;
                w_wdata = r_shadow & ~32'h0000_0001;
            end
            c_OP_CLEAR: begin
                w_wen   = 1'b0;
                w_last  = 1'b1;
                w_addr  = c_A_CFG_LO;
                w_wdata = r_shadow | 32'h0000_0002;
            end
            default: begin
                w_wen  = 1'b1;
                w_last = (r_step == 2'd2);
                w_addr = (r_step == 2'd1) ? c_A_VAL_LO : c_A_VAL_HI;
            end
        endcase
    end

    // Address/data are derived from latched command state, so they stay put while gnt is withheld
    assign w_issue     = (r_state == c_S_ISSUE);
    assign tmr_req_o   = w_issue;
    assign tmr_addr_o  = w_issue ? w_addr  : 32'h0000_0000;
    assign tmr_wen_o   = w_issue ? w_wen   : 1'b1;
    assign tmr_wdata_o = w_issue ? w_wdata : 32'h0000_0000;
    assign tmr_be_o    = 4'hF;
    assign tmr_id_o    = c_TXN_ID;

    assign cmd_ready_o = (r_state == c_S_IDLE);
    assign rsp_valid_o = (r_state == c_S_RESP);
    assign rsp_data_o  = r_rsp_data;
    assign rsp_err_o   = r_rsp_err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= c_S_IDLE;
            r_op       <= c_OP_START;
            r_period   <= 32'h0000_0000;
            r_oneshot  <= 1'b0;
            r_presc    <= 8'h00;
            r_step     <= 2'd0;
            r_retry    <= '0;
            r_h0       <= 32'h0000_0000;
            r_lo       <= 32'h0000_0000;
            r_shadow   <= 32'h0000_0000;
            r_rsp_data <= 64'h0;
            r_rsp_err  <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (cmd_valid_i) begin
                        r_op      <= cmd_op_i;
                        r_period  <= cmd_period_i;
                        r_oneshot <= cmd_oneshot_i;
                        r_presc   <= cmd_presc_i;
                        r_step    <= 2'd0;
                        r_retry   <= '0;
                        r_state   <= c_S_ISSUE;
                    end
                end
                c_S_ISSUE: begin
                    if (tmr_gnt_i) begin
                        r_state <= c_S_WAIT;
                    end
                end
                c_S_WAIT: begin
                    if (tmr_r_valid_i) begin
                        if (r_op == c_OP_READ64) begin
                            case (r_step)
                                2'd0: begin
                                    r_h0    <= tmr_r_rdata_i;
                                    r_step  <= 2'd1;
                                    r_state <= c_S_ISSUE;
                                end
                                2'd1: begin
                                    r_lo    <= tmr_r_rdata_i;
                                    r_step  <= 2'd2;
                                    r_state <= c_S_ISSUE;
                                end
                                default: begin
                                    // A moved high word means lo may have wrapped between reads
                                    if (tmr_r_rdata_i == r_h0) begin
                                        r_rsp_data <= {r_h0, r_lo};
                                        r_rsp_err  <= 1'b0;
                                        r_state    <= c_S_RESP;
                                    end else if (r_retry < c_MAX_RETRY) begin
                                        r_retry <= r_retry + c_RETRY_W'(1);
                                        r_step  <= 2'd0;
                                        r_state <= c_S_ISSUE;
                                    end else begin
                                        r_rsp_data <= {tmr_r_rdata_i, r_lo};
                                        r_rsp_err  <= 1'b1;
                                        r_state    <= c_S_RESP;
                                    end
                                end
                            endcase
                        end else if (w_last) begin
                            r_rsp_data <= 64'h0;
                            r_rsp_err  <= 1'b0;
                            r_state    <= c_S_RESP;
                            if (r_op == c_OP_START) begin
                                r_shadow <= w_cfg_start & ~32'h0000_0002;
                            end else if (r_op == c_OP_STOP) begin
                                r_shadow <= r_shadow & ~32'h0000_0001;
                            end
                        end else begin
                            r_step  <= r_step + 2'd1;
                            r_state <= c_S_ISSUE;
                        end
                    end
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_soc_timer_cmd_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_soc_timer_cmd_seq
//  Brief    : Randomized self-checking bench for soc_timer_cmd_seq with a
//             behavioural timer responder and command-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_soc_timer_cmd_seq;

    localparam int MAX_RETRY = 3;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [1:0]  cmd_op_i = 2'd0;
    logic [31:0] cmd_period_i = 32'h0;
    logic        cmd_oneshot_i = 1'b0;
    logic [7:0]  cmd_presc_i = 8'h0;
    logic        rsp_valid_o;
    logic [63:0] rsp_data_o;
    logic        rsp_err_o;
    logic        tmr_req_o;
    logic [31:0] tmr_addr_o;
    logic        tmr_wen_o;
    logic [31:0] tmr_wdata_o;
    logic [3:0]  tmr_be_o;
    logic [4:0]  tmr_id_o;
    logic        tmr_gnt_i = 1'b0;
    logic        tmr_r_valid_i = 1'b0;
    logic [31:0] tmr_r_rdata_i = 32'h0;

    soc_timer_cmd_seq #(
        .ID_WIDTH  (5),
        .TXN_ID    (0),
        .MAX_RETRY (MAX_RETRY)
    ) u_dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .cmd_valid_i   (cmd_valid_i),
        .cmd_ready_o   (cmd_ready_o),
        .cmd_op_i      (cmd_op_i),
        .cmd_period_i  (cmd_period_i),
        .cmd_oneshot_i (cmd_oneshot_i),
        .cmd_presc_i   (cmd_presc_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_data_o    (rsp_data_o),
        .rsp_err_o     (rsp_err_o),
        .tmr_req_o     (tmr_req_o),
        .tmr_addr_o    (tmr_addr_o),
        .tmr_wen_o     (tmr_wen_o),
        .tmr_wdata_o   (tmr_wdata_o),
        .tmr_be_o      (tmr_be_o),
        .tmr_id_o      (tmr_id_o),
        .tmr_gnt_i     (tmr_gnt_i),
        .tmr_r_valid_i (tmr_r_valid_i),
        .tmr_r_rdata_i (tmr_r_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int vectors = 0;
    int miscompares = 0;

    // Timer responder configuration (-1 = random 0..3 cycles)
    int          gnt_delay_cfg = 0;
    int          rv_delay_cfg  = 0;
    logic [31:0] hi_vals [1024];
    logic [31:0] lo_val = 32'h0;

    // Responder-owned state
    int          hi_idx = 0;
    logic [64:0] log_txn [4096];
    int          log_cnt = 0;
    int          req_cnt = 0;
    int          cur_gd = 0;
    int          rv_left = 0;
    bit          pending = 1'b0;
    logic [31:0] pend_rdata = 32'h0;
    logic [64:0] hold_txn = '0;
    int          stab_viol = 0;
    int          last_stall = 0;

    // Monitor-owned state
    int          cyc = 0;
    int          rsp_cnt = 0;
    int          rsp_cyc = 0;
    logic [63:0] rsp_d = 64'h0;
    logic        rsp_e = 1'b0;
    int          ready_viol = 0;

    // Driver-owned state
    bit          busy = 1'b0;
    int          acc_cyc = 0;
    int          log_base = 0;

    // Reference model state
    logic [31:0] m_shadow = 32'h0;
    logic [64:0] exp_txn [64];
    int          exp_n = 0;
    logic [63:0] exp_rsp = 64'h0;
    logic        exp_err = 1'b0;

    always @(negedge clk_i) begin
        tmr_gnt_i     = 1'b0;
        tmr_r_valid_i = 1'b0;
        if (rst_i) begin
            pending = 1'b0;
            req_cnt = 0;
        end else if (pending) begin
            if (rv_left == 0) begin
                tmr_r_valid_i = 1'b1;
                tmr_r_rdata_i = pend_rdata;
                pending = 1'b0;
            end else begin
                rv_left--;
            end
        end else if (tmr_req_o) begin
            if (req_cnt == 0) begin
                cur_gd   = (gnt_delay_cfg >= 0) ? gnt_delay_cfg : int'($urandom_range(0, 3));
                hold_txn = {tmr_addr_o, tmr_wen_o, tmr_wen_o ? 32'h0 : tmr_wdata_o};
            end else if ({tmr_addr_o, tmr_wen_o, tmr_wen_o ? 32'h0 : tmr_wdata_o} !== hold_txn) begin
                stab_viol++;
            end
            if (req_cnt >= cur_gd) begin
                tmr_gnt_i = 1'b1;
                last_stall = req_cnt;
                log_txn[log_cnt % 4096] = {tmr_addr_o, tmr_wen_o, tmr_wen_o ? 32'h0 : tmr_wdata_o};
                log_cnt++;
                if (tmr_wen_o && tmr_addr_o == 32'h0C) begin
                    pend_rdata = hi_vals[hi_idx % 1024];
                    hi_idx++;
                end else if (tmr_wen_o && tmr_addr_o == 32'h08) begin
                    pend_rdata = lo_val;
                end else begin
                    pend_rdata = $urandom;
                end
                pending = 1'b1;
                req_cnt = 0;
                rv_left = (rv_delay_cfg >= 0) ? rv_delay_cfg : int'($urandom_range(0, 3));
            end else begin
                req_cnt++;
            end
        end
    end

    always @(negedge clk_i) begin
        cyc++;
        if (busy && cmd_ready_o) ready_viol++;
        if (rsp_valid_o) begin
            rsp_cnt++;
            rsp_cyc = cyc;
            rsp_d   = rsp_data_o;
            rsp_e   = rsp_err_o;
        end
    end

    // Command-level reference: what the timer should see and what comes back
    task automatic model_cmd(input logic [1:0] op, input logic [31:0] per,
                             input logic os, input logic [7:0] pr);
        logic [31:0] c;
        logic [31:0] h0;
        logic [31:0] h1;
        exp_n   = 0;
        exp_rsp = 64'h0;
        exp_err = 1'b0;
        case (op)
            2'd0: begin
                c = 32'h17 | (32'(os) << 5) | (32'(pr != 8'd0) << 6) | (32'(pr) << 8);
                exp_txn[0] = {32'h00, 1'b0, 32'h0};
                exp_txn[1] = {32'h10, 1'b0, per};
                exp_txn[2] = {32'h00, 1'b0, c};
                exp_n = 3;
                m_shadow = c & ~32'h2;
            end
            2'd1: begin
                m_shadow = m_shadow & ~32'h1;
                exp_txn[0] = {32'h00, 1'b0, m_shadow};
                exp_n = 1;
            end
            2'd2: begin
                exp_txn[0] = {32'h00, 1'b0, m_shadow | 32'h2};
                exp_n = 1;
            end
            default: begin
                for (int a = 0; a <= MAX_RETRY; a++) begin
                    h0 = hi_vals[(hi_idx + 2 * a) % 1024];
                    h1 = hi_vals[(hi_idx + 2 * a + 1) % 1024];
                    exp_txn[exp_n]     = {32'h0C, 1'b1, 32'h0};
                    exp_txn[exp_n + 1] = {32'h08, 1'b1, 32'h0};
                    exp_txn[exp_n + 2] = {32'h0C, 1'b1, 32'h0};
                    exp_n += 3;
                    if (h0 == h1) begin
                        exp_rsp = {h0, lo_val};
                        break;
                    end
                    if (a == MAX_RETRY) begin
                        exp_rsp = {h1, lo_val};
                        exp_err = 1'b1;
                    end
                end
            end
        endcase
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [31:0] per,
                            input logic os, input logic [7:0] pr);
        int n0;
        int budget;
        @(negedge clk_i);
        budget = 0;
        while (!cmd_ready_o && budget < 100) begin
            @(negedge clk_i);
            budget++;
        end
        cmd_valid_i   = 1'b1;
        cmd_op_i      = op;
        cmd_period_i  = per;
        cmd_oneshot_i = os;
        cmd_presc_i   = pr;
        n0       = rsp_cnt;
        log_base = log_cnt;
        @(posedge clk_i);
        acc_cyc = cyc;
        busy    = 1'b1;
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        budget = 0;
        while (rsp_cnt == n0 && budget < 600) begin
            @(posedge clk_i);
            budget++;
        end
        busy = 1'b0;
        if (rsp_cnt == n0) begin
            vectors++;
            miscompares++;
            $display("FAIL rsp_timeout: no response for op %0d within %0d cycles", op, budget);
        end
    endtask

    task automatic test_reset;
        @(negedge clk_i);
        vectors++;
        if ({cmd_ready_o, rsp_valid_o, tmr_req_o, tmr_wen_o} !== 4'b1001) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b expected 1001", {cmd_ready_o, rsp_valid_o, tmr_req_o, tmr_wen_o});
        end
        vectors++;
        if ({tmr_addr_o, tmr_wdata_o, rsp_data_o, rsp_err_o} !== 129'h0) begin
            miscompares++;
            $display("FAIL reset_data: got addr %h wdata %h rsp %h err %b expected all zero",
                     tmr_addr_o, tmr_wdata_o, rsp_data_o, rsp_err_o);
        end
        vectors++;
        if ({tmr_be_o, tmr_id_o} !== {4'hF, 5'd0}) begin
            miscompares++;
            $display("FAIL reset_be_id: got be %h id %h expected be f id 0", tmr_be_o, tmr_id_o);
        end
    endtask

    task automatic test_start_basic;
        gnt_delay_cfg = 0;
        rv_delay_cfg  = 0;
        model_cmd(2'd0, 32'd100, 1'b0, 8'd0);
        send_cmd(2'd0, 32'd100, 1'b0, 8'd0);
        vectors++;
        if (log_cnt - log_base !== 3) begin
            miscompares++;
            $display("FAIL start_count: got %0d writes expected 3", log_cnt - log_base);
        end
        vectors++;
        if ({log_txn[log_base], log_txn[log_base + 1], log_txn[log_base + 2]} !==
            {32'h00, 1'b0, 32'h0, 32'h10, 1'b0, 32'h64, 32'h00, 1'b0, 32'h17}) begin
            miscompares++;
            $display("FAIL start_writes: got %h %h %h expected 00/0 10/64 00/17",
                     log_txn[log_base], log_txn[log_base + 1], log_txn[log_base + 2]);
        end
        vectors++;
        if (rsp_cyc - acc_cyc !== 7) begin
            miscompares++;
            $display("FAIL start_latency: got %0d cycles expected 7", rsp_cyc - acc_cyc);
        end
        vectors++;
        if ({rsp_d, rsp_e} !== 65'h0) begin
            miscompares++;
            $display("FAIL start_rsp: got %h err %b expected 0 err 0", rsp_d, rsp_e);
        end
    endtask

    task automatic test_start_stop;
        model_cmd(2'd0, 32'd5000, 1'b1, 8'd4);
        send_cmd(2'd0, 32'd5000, 1'b1, 8'd4);
        vectors++;
        if (log_txn[log_base + 2] !== {32'h00, 1'b0, 32'h0477}) begin
            miscompares++;
            $display("FAIL start_presc_cfg: got %h expected 00/0477", log_txn[log_base + 2]);
        end
        model_cmd(2'd1, 32'd0, 1'b0, 8'd0);
        send_cmd(2'd1, 32'd0, 1'b0, 8'd0);
        vectors++;
        if (log_cnt - log_base !== 1 || log_txn[log_base] !== {32'h00, 1'b0, 32'h0474}) begin
            miscompares++;
            $display("FAIL stop_write: got %0d txns first %h expected 1 txn 00/0474",
                     log_cnt - log_base, log_txn[log_base]);
        end
    endtask

    task automatic test_read64;
        lo_val = 32'hFFFF_FFF0;
        hi_vals[hi_idx % 1024]       = 32'h1;
        hi_vals[(hi_idx + 1) % 1024] = 32'h1;
        send_cmd(2'd3, 32'd0, 1'b0, 8'd0);
        vectors++;
        if ({log_txn[log_base][64:33], log_txn[log_base + 1][64:33], log_txn[log_base + 2][64:33]} !==
            {32'h0C, 32'h08, 32'h0C} || log_cnt - log_base !== 3) begin
            miscompares++;
            $display("FAIL read64_addrs: got %0d reads expected 3 at 0c 08 0c", log_cnt - log_base);
        end
        vectors++;
        if ({rsp_d, rsp_e, 32'(rsp_cyc - acc_cyc)} !== {64'h0000_0001_FFFF_FFF0, 1'b0, 32'd7}) begin
            miscompares++;
            $display("FAIL read64_clean: got %h err %b lat %0d expected 00000001fffffff0 err 0 lat 7",
                     rsp_d, rsp_e, rsp_cyc - acc_cyc);
        end
        for (int k = 0; k < 4; k++) hi_vals[(hi_idx + k) % 1024] = (k == 0) ? 32'h1 : 32'h2;
        send_cmd(2'd3, 32'd0, 1'b0, 8'd0);
        vectors++;
        if (log_cnt - log_base !== 6 || rsp_d !== {32'h2, 32'hFFFF_FFF0} || rsp_e !== 1'b0) begin
            miscompares++;
            $display("FAIL read64_retry: got %0d reads %h err %b expected 6 reads 00000002fffffff0 err 0",
                     log_cnt - log_base, rsp_d, rsp_e);
        end
        for (int k = 0; k < 8; k++) hi_vals[(hi_idx + k) % 1024] = 32'h10 + 32'(k);
        send_cmd(2'd3, 32'd0, 1'b0, 8'd0);
        vectors++;
        if (log_cnt - log_base !== 3 * (MAX_RETRY + 1) || rsp_d !== {32'h17, 32'hFFFF_FFF0} || rsp_e !== 1'b1) begin
            miscompares++;
            $display("FAIL read64_exhaust: got %0d reads %h err %b expected 12 reads 00000017fffffff0 err 1",
                     log_cnt - log_base, rsp_d, rsp_e);
        end
    endtask

    task automatic test_clear_stall;
        int sv0;
        gnt_delay_cfg = 5;
        sv0 = stab_viol;
        model_cmd(2'd2, 32'd0, 1'b0, 8'd0);
        send_cmd(2'd2, 32'd0, 1'b0, 8'd0);
        vectors++;
        if (stab_viol - sv0 !== 0 || last_stall !== 5) begin
            miscompares++;
            $display("FAIL clear_stall: got %0d unstable cycles stall %0d expected 0 unstable stall 5",
                     stab_viol - sv0, last_stall);
        end
        vectors++;
        if (log_cnt - log_base !== 1 || log_txn[log_base] !== exp_txn[0]) begin
            miscompares++;
            $display("FAIL clear_write: got %0d txns %h expected 1 txn %h",
                     log_cnt - log_base, log_txn[log_base], exp_txn[0]);
        end
        vectors++;
        if (ready_viol !== 0) begin
            miscompares++;
            $display("FAIL ready_busy: got %0d ready cycles while busy expected 0", ready_viol);
        end
        gnt_delay_cfg = 0;
    endtask

    task automatic test_reset_mid;
        int n0;
        gnt_delay_cfg = 0;
        rv_delay_cfg  = 4;
        @(negedge clk_i);
        while (!cmd_ready_o) @(negedge clk_i);
        cmd_valid_i = 1'b1;
        cmd_op_i    = 2'd0;
        cmd_presc_i = 8'd9;
        n0 = rsp_cnt;
        @(posedge clk_i);
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        vectors++;
        if ({cmd_ready_o, tmr_req_o, rsp_valid_o, tmr_wen_o} !== 4'b1001) begin
            miscompares++;
            $display("FAIL reset_mid: got ready/req/rsp/wen %b expected 1001",
                     {cmd_ready_o, tmr_req_o, rsp_valid_o, tmr_wen_o});
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        m_shadow = 32'h0;
        rv_delay_cfg = 0;
        repeat (10) @(negedge clk_i);
        vectors++;
        if (rsp_cnt !== n0) begin
            miscompares++;
            $display("FAIL reset_norsp: got %0d responses expected %0d", rsp_cnt, n0);
        end
        model_cmd(2'd2, 32'd0, 1'b0, 8'd0);
        send_cmd(2'd2, 32'd0, 1'b0, 8'd0);
        vectors++;
        if (log_txn[log_base] !== {32'h00, 1'b0, 32'h2}) begin
            miscompares++;
            $display("FAIL reset_shadow: got %h expected 00/00000002", log_txn[log_base]);
        end
    endtask

    task automatic test_random;
        logic [1:0]  op;
        logic [31:0] per;
        logic        os;
        logic [7:0]  pr;
        gnt_delay_cfg = -1;
        rv_delay_cfg  = -1;
        for (int n = 0; n < 40; n++) begin
            op  = 2'($urandom_range(0, 3));
            per = $urandom;
            os  = 1'($urandom_range(0, 1));
            pr  = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom);
            if (op == 2'd3) begin
                lo_val = $urandom;
                for (int k = 0; k < 2 * (MAX_RETRY + 1); k++)
                    hi_vals[(hi_idx + k) % 1024] = 32'($urandom_range(0, 2));
            end
            model_cmd(op, per, os, pr);
            send_cmd(op, per, os, pr);
            vectors++;
            if (log_cnt - log_base !== exp_n) begin
                miscompares++;
                $display("FAIL rand_count[%0d]: got %0d txns expected %0d (op %0d)",
                         n, log_cnt - log_base, exp_n, op);
            end else begin
                for (int i = 0; i < exp_n; i++) begin
                    vectors++;
                    if (log_txn[(log_base + i) % 4096] !== exp_txn[i]) begin
                        miscompares++;
                        $display("FAIL rand_txn[%0d.%0d]: got %h expected %h",
                                 n, i, log_txn[(log_base + i) % 4096], exp_txn[i]);
                    end
                end
            end
            vectors++;
            if ({rsp_d, rsp_e} !== {exp_rsp, exp_err}) begin
                miscompares++;
                $display("FAIL rand_rsp[%0d]: got %h err %b expected %h err %b",
                         n, rsp_d, rsp_e, exp_rsp, exp_err);
            end
        end
        vectors++;
        if (ready_viol !== 0) begin
            miscompares++;
            $display("FAIL rand_ready_busy: got %0d ready cycles while busy expected 0", ready_viol);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        test_reset;
        test_start_basic;
        test_start_stop;
        test_read64;
        test_clear_stall;
        test_reset_mid;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/soc_timer_cmd_seq.md
Name: soc_timer_cmd_seq

Overview:
Command sequencer that programs and samples the low 32-bit channel of the SoC timer through its req/gnt/r_valid register port. Software-side masters issue one high-level command (START, STOP, CLEAR, READ64) over a valid/ready interface. The block expands each command into ordered register transactions and returns a single response. It sits between a local control master and the timer's register port and is the only master on that port.

Parameters:
ID_WIDTH, 5, width of the transaction ID driven to the timer
TXN_ID, 0, constant ID value driven on tmr_id_o
MAX_RETRY, 3, extra READ64 attempts allowed after the first inconsistent sample (counter width = clog2(MAX_RETRY+1))

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active high
cmd_valid_i  in  1  command offered
cmd_ready_o  out  1  sequencer idle; command accepted when valid&ready
cmd_op_i  in  2  0=START 1=STOP 2=CLEAR 3=READ64
cmd_period_i  in  32  START compare value
cmd_oneshot_i  in  1  START one-shot select
cmd_presc_i  in  8  START prescaler compare value; 0 = prescaler off
rsp_valid_o  out  1  one-cycle response pulse
rsp_data_o  out  64  READ64 result {hi,lo}; 0 for other ops
rsp_err_o  out  1  READ64 retries exhausted
tmr_req_o  out  1  register request
tmr_addr_o  out  32  register byte address (bits 31:6 always 0)
tmr_wen_o  out  1  0=write, 1=read
tmr_wdata_o  out  32  write data
tmr_be_o  out  4  always 4'hF
tmr_id_o  out  ID_WIDTH  always TXN_ID
tmr_gnt_i  in  1  request accepted
tmr_r_valid_i  in  1  response for the accepted request (reads and writes)
tmr_r_rdata_i  in  32  read data

Behaviour:
- Register offsets: CFG_LO 0x00, VAL_LO 0x08, VAL_HI 0x0C, CMP_LO 0x10. CFG bits: 0 enable, 1 reset, 2 irq, 4 cmp_clr, 5 one_shot, 6 presc_en, 15:8 presc value, 31 mode64 (always 0).
- Reset: state IDLE, cmd_ready_o=1, rsp_valid_o=0, rsp_data_o=0, rsp_err_o=0, tmr_req_o=0, tmr_wen_o=1, tmr_addr_o=0, tmr_wdata_o=0, shadow_cfg=0, retry count=0. Reset mid-sequence aborts it; no response is produced.
- FSM: IDLE -> ISSUE on accept (op fields latched); ISSUE drives tmr_req_o=1 with the current step's addr/wen/wdata held stable until tmr_gnt_i; on gnt -> WAIT; WAIT holds req=0 until tmr_r_valid_i, then takes the next step (ISSUE) or finishes (RESP); RESP pulses rsp_valid_o for 1 cycle -> IDLE. Maximum one outstanding transaction.
- r_valid arriving in the same cycle as gnt is ignored. Any r_valid in IDLE/ISSUE is ignored.
- START: W CFG_LO=0; W CMP_LO=period; W CFG_LO=C, where C = enable|reset|irq|cmp_clr|(oneshot<<5)|((presc!=0)<<6)|(presc<<8). shadow_cfg <= C with the reset bit cleared.
- STOP: W CFG_LO = shadow_cfg & ~1; shadow updated to the same value.
- CLEAR: W CFG_LO = shadow_cfg | 2; shadow is unchanged.
- READ64: R VAL_HI->h0; R VAL_LO->lo; R VAL_HI->h1.
  - h1==h0: respond {h0,lo}, err=0.
  - Otherwise, if retries<MAX_RETRY: increment and restart at the first read.
  - Otherwise: respond {h1,lo}, err=1.
  - Retry count clears on accept.
- Minimum latency, accept to rsp_valid, with gnt in ISSUE and r_valid the next cycle: 2 cycles per transaction + 1. START = 7 cycles; a clean READ64 = 7 cycles.
- rsp_data_o/rsp_err_o are registered, valid only with rsp_valid_o, and hold until the next response.
- cmd_ready_o=1 only in IDLE, so the cycle after rsp_valid_o can accept a new command.

Test Plan:
- START period=100, oneshot=0, presc=0, gnt/r_valid immediate -> exactly 3 writes in order: (0x00,0x0), (0x10,0x64), (0x00,0x17); rsp_valid_o on cycle 7 after accept; rsp_data_o=0.
- START presc=4, oneshot=1, then STOP -> last START write 0x00,0x0477; STOP write 0x00,0x0474.
- READ64 with VAL_HI=0x1, VAL_LO=0xFFFF_FFF0 stable -> reads at 0x0C, 0x08, 0x0C; rsp_data_o=0x0000_0001_FFFF_FFF0; err=0.
- READ64 with VAL_HI returning 1 then 2 (first attempt) then stable 2 -> 6 reads; rsp_data_o hi=2; err=0. With HI changing on every read -> 3*(MAX_RETRY+1)=12 reads, then err=1.
- gnt withheld 5 cycles during a CLEAR -> req, addr and wdata stable throughout; single write 0x00 = shadow|0x2; cmd_ready_o=0 until after the response.
- rst_i asserted while in WAIT of START -> next cycle: IDLE, req=0, cmd_ready_o=1, no rsp_valid_o, shadow_cfg=0.
